mdu_seq: RTL

Multi-cycle sequencer for the RV32M multiply/divide instructions. It reuses the shared 32-bit carry-lookahead adder instead of instantiating its own multiplier or divider. The block sits beside the ALU in the execute stage. It takes one operation over a valid/ready request port, drives the adder's operands and carry-in every cycle, and returns a 32-bit result over a valid/ready response port.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/mdu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU and the RV32M multiply/divide
// sequencer that borrows the ALU's carry-lookahead adder.
//   XLEN           : datapath width (only 32 is supported)
//   MDU_*          : RV32M funct3 encodings
//   mdu_state_t    : sequencer FSM states
//   opSignedA/B    : which operands are treated as two's complement per op
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        FIX_LO,
        FIX_HI,
        DONE
    } mdu_state_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM
    function automatic logic opSignedA(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU keeps rs2 unsigned)
    function automatic logic opSignedB(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// mdu_seq
// Multi-cycle RV32M multiply/divide sequencer. Operands are made positive,
// 32 shift-add (multiply) or restoring-subtract (divide) steps run through
// the external shared adder, then the sign of the result is restored.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   req_valid_i/req_ready_o     : request handshake (op_i, a_i, b_i)
//   flush_i                     : abandon any operation in flight
//   resp_valid_o/resp_ready_i   : response handshake (result_o)
//   busy_o                      : sequencer owns the shared adder
//   add_a_o/add_b_o/add_cin_o   : shared adder operands
//   add_sum_i/add_cout_i        : shared adder result, same cycle
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    output logic [XLEN-1:0] add_a_o,
    output logic [XLEN-1:0] add_b_o,
    output logic            add_cin_o,
    input  logic [XLEN-1:0] add_sum_i,
    input  logic            add_cout_i
);
    import alu_pkg::*;

    mdu_state_t      r_state;
    mdu_state_t      w_next;

    logic [2:0]      r_op;
    logic            r_negA;
    logic            r_negB;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_div;
    logic [4:0]      r_cnt;
    logic            r_carry;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_divByZero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_specialResult;
    logic            w_isMul;
    logic            w_isRem;
    logic            w_signsDiffer;
    logic            w_fixLo;
    logic            w_fixHi;
    logic [XLEN-1:0] w_fixWord;
    logic [XLEN:0]   w_shifted;
    logic            w_trialOk;

    assign req_ready_o  = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign resp_valid_o = (r_state == DONE);
    assign result_o     = r_result;

    assign w_accept = req_valid_i & req_ready_o & ~flush_i;

    // Divide-by-zero and signed overflow have fixed answers, so they skip the
    // datapath entirely and respond one cycle after acceptance.
    assign w_divByZero = op_i[2] && (b_i == '0);
    assign w_overflow  = ((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                         (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign w_special   = w_divByZero | w_overflow;
    // REM/REMU by zero return the dividend; overflow DIV returns the dividend
    // too (0x8000_0000) while overflow REM returns zero.
    assign w_specialResult = w_divByZero ? (op_i[1] ? a_i : '1)
                                         : (op_i[1] ? '0  : a_i);

    assign w_isMul       = ~r_op[2];
    assign w_isRem       = r_op[2] & r_op[1];
    assign w_signsDiffer = r_negA ^ r_negB;

    // Sign restore: products and quotients take the XOR of operand signs,
    // remainders take the dividend's sign. Only the high product word ever
    // needs the second negation step.
    always_comb begin
        w_fixLo = 1'b0;
        w_fixHi = 1'b0;
        case (r_op)
            MDU_MULH, MDU_MULHSU: begin
                w_fixLo = w_signsDiffer;
                w_fixHi = w_signsDiffer;
            end
            MDU_DIV: w_fixLo = w_signsDiffer;
            MDU_REM: w_fixLo = r_negA;
            default: ;
        endcase
    end

    // Remainder lives in hi, quotient/low product in lo.
    assign w_fixWord = w_isRem ? r_hi : r_lo;

    // Restoring-division shift: remainder gets the next dividend bit from
    // the top of q; a 33rd bit survives when the remainder had its MSB set.
    assign w_shifted = {r_hi, r_lo[XLEN-1]};
    assign w_trialOk = w_shifted[XLEN] | add_cout_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and shared-adder drive, all from registered state
    always_comb begin
        w_next    = r_state;
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? DONE : NEG_A;
                end
            end
            NEG_A: begin
                add_a_o   = r_negA ? ~r_lo : r_lo;
                add_cin_o = r_negA;
                w_next    = NEG_B;
            end
            NEG_B: begin
                add_a_o   = r_negB ? ~r_div : r_div;
                add_cin_o = r_negB;
                w_next    = ITER;
            end
            ITER: begin
                if (w_isMul) begin
                    add_a_o = r_hi;
                    add_b_o = r_lo[0] ? r_div : '0;
                end else begin
                    add_a_o   = w_shifted[XLEN-1:0];
                    add_b_o   = ~r_div;
                    add_cin_o = 1'b1;
                end
                if (r_cnt == 5'd31) begin
                    w_next = FIX_LO;
                end
            end
            FIX_LO: begin
                add_a_o   = w_fixLo ? ~w_fixWord : w_fixWord;
                add_cin_o = w_fixLo;
                w_next    = FIX_HI;
            end
            FIX_HI: begin
                add_a_o   = w_fixHi ? ~r_hi : r_hi;
                add_cin_o = w_fixHi & r_carry;
                w_next    = DONE;
            end
            DONE: begin
                if (resp_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush_i && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    // Datapath registers: operand capture, magnitude conversion, iteration
    // and sign restore, each step consuming the adder result of its cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= '0;
            r_negA   <= 1'b0;
            r_negB   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= op_i;
                        r_negA <= opSignedA(op_i) & a_i[XLEN-1];
                        r_negB <= opSignedB(op_i) & b_i[XLEN-1];
                        r_hi   <= '0;
                        r_lo   <= a_i;
                        r_div  <= b_i;
                        r_cnt  <= '0;
                        if (w_special) begin
                            r_result <= w_specialResult;
                        end
                    end
                end
                NEG_A: r_lo  <= add_sum_i;
                NEG_B: r_div <= add_sum_i;
                ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_isMul) begin
                        {r_hi, r_lo} <= {add_cout_i, add_sum_i, r_lo[XLEN-1:1]};
                    end else begin
                        r_hi <= w_trialOk ? add_sum_i : w_shifted[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_trialOk};
                    end
                end
                FIX_LO: begin
                    if (w_isRem) begin
                        r_hi <= add_sum_i;
                    end else begin
                        r_lo <= add_sum_i;
                    end
                    r_carry <= add_cout_i;
                end
                FIX_HI: begin
                    if (!flush_i) begin
                        case (r_op)
                            MDU_MUL:                          r_result <= r_lo;
                            MDU_MULH, MDU_MULHSU, MDU_MULHU:  r_result <= add_sum_i;
                            MDU_DIV, MDU_DIVU:                r_result <= r_lo;
                            default:                          r_result <= r_hi;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
